// File: rtl/upuart_tx.sv
// -----------------------------------------------------------------------------
// upuart_tx -- UltiSoC UART transmitter
//
// Pops bytes from a first-word-fall-through TX FIFO and serialises each one
// onto txd as an 8N1 frame (8N2 when STOP_BITS = 2). The frame is sent as
// start bit (0), data bits LSB first, then the stop bits (1). Bit timing
// comes from the shared baud tick uclk, which is a single-clk enable running
// at OVERSAMPLE times the baud rate. Each bit lasts exactly OVERSAMPLE ticks.
//
// Parameters
//   OVERSAMPLE  uclk ticks per bit, 2..64 (default 16)
//   STOP_BITS   stop bits per frame, 1 or 2 (default 1)
//
// Ports
//   clk         system clock
//   nrst        asynchronous active-low reset
//   data_in     FIFO head byte, valid while fifo_empty = 0
//   fifo_empty  TX FIFO empty flag
//   data_rd     FIFO pop strobe, exactly one clk wide
//   tx_en       transmitter enable; gates only the start of new frames
//   uclk        baud tick enable, one clk wide
//   txd         registered serial output, idles high
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module upuart_tx #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] data_in,
    input  logic       fifo_empty,
    output logic       data_rd,
    input  logic       tx_en,
    input  logic       uclk,
    output logic       txd,
    output logic       busy
);

    localparam int              TW          = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_RELOAD = TW'(OVERSAMPLE - 1);
    localparam logic            STOP_RELOAD = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e        state_q,   state_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic [TW-1:0] tick_q,    tick_d;
    logic [2:0]    bitcnt_q,  bitcnt_d;
    logic          stopcnt_q, stopcnt_d;
    logic          txd_q,     txd_d;
    logic          data_rd_q, data_rd_d;
    logic          busy_q,    busy_d;

    logic          can_start;
    logic          tick_zero;
    logic          start_frame;

    // A new frame may begin only while enabled and with a byte at the FIFO head.
    assign can_start = tx_en & ~fifo_empty;
    assign tick_zero = (tick_q == '0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        shreg_d     = shreg_q;
        tick_d      = tick_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        txd_d       = txd_q;
        start_frame = 1'b0;
        // The pop strobe self-clears on the next clk edge regardless of uclk,
        // so it stays one clk wide even when uclk is tied high.
        data_rd_d   = 1'b0;

        if (uclk) begin
            unique case (state_q)
                S_IDLE: begin
                    txd_d = 1'b1;
                    if (can_start) begin
                        start_frame = 1'b1;
                    end
                end

                S_START: begin
                    if (tick_zero) begin
                        txd_d    = shreg_q[0];
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = 3'd7;
                        tick_d   = TICK_RELOAD;
                        state_d  = S_DATA;
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end

                S_DATA: begin
                    if (tick_zero) begin
                        tick_d = TICK_RELOAD;
                        if (bitcnt_q != 3'd0) begin
                            txd_d    = shreg_q[0];
                            shreg_d  = {1'b0, shreg_q[7:1]};
                            bitcnt_d = bitcnt_q - 3'd1;
                        end else begin
                            txd_d     = 1'b1;
                            stopcnt_d = STOP_RELOAD;
                            state_d   = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end

                S_STOP: begin
                    if (tick_zero) begin
                        if (stopcnt_q) begin
                            // Second stop bit of an 8N2 frame.
                            stopcnt_d = 1'b0;
                            tick_d    = TICK_RELOAD;
                        end else if (can_start) begin
                            // Chain straight into the next frame: this edge is
                            // already a tick, so there is no idle gap.
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase

            if (start_frame) begin
                shreg_d   = data_in;
                data_rd_d = 1'b1;
                txd_d     = 1'b0;
                tick_d    = TICK_RELOAD;
                state_d   = S_START;
            end
        end

        // busy is registered from the next state so it rises on the start edge
        // and falls on the edge that enters IDLE.
        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            shreg_q   <= 8'h00;
            tick_q    <= '0;
            bitcnt_q  <= 3'd0;
            stopcnt_q <= 1'b0;
            txd_q     <= 1'b1;
            data_rd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // values computed for this edge, independent of statement order.
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            tick_q    <= tick_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            txd_q     <= txd_d;
            data_rd_q <= data_rd_d;
            busy_q    <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign data_rd = data_rd_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_upuart_tx.sv
// -----------------------------------------------------------------------------
// tb_upuart_tx -- directed testbench for upuart_tx
//
// dut0: default configuration (OVERSAMPLE=16, STOP_BITS=1), uclk every 4 clk,
//       so one bit lasts 64 clk and a frame 640 clk.
// dut1: OVERSAMPLE=8, STOP_BITS=2, uclk tied high, so one bit lasts 8 clk and a
//       frame 88 clk. Its line also feeds a simple receiver model.
// Each DUT has a small FIFO model (queue) that pops on data_rd.
// Outputs are sampled on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_upuart_tx;

    logic clk;
    logic nrst;

    // dut0 signals
    logic [7:0] data_in0;
    logic       fifo_empty0;
    logic       data_rd0;
    logic       tx_en0;
    logic       uclk0;
    logic       txd0;
    logic       busy0;

    // dut1 signals
    logic [7:0] data_in1;
    logic       fifo_empty1;
    logic       data_rd1;
    logic       tx_en1;
    logic       uclk1;
    logic       txd1;
    logic       busy1;

    int n_checks;
    int n_errors;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] rx_q[$];
    int         rx_ferr;
    logic       rx_prev;
    int         div0;

    // Monitor mux: the frame checker looks at whichever DUT sel picks.
    logic sel;
    logic mon_txd, mon_rd, mon_busy;
    assign mon_txd  = sel ? txd1     : txd0;
    assign mon_rd   = sel ? data_rd1 : data_rd0;
    assign mon_busy = sel ? busy1    : busy0;

    upuart_tx u_dut0 (
        .clk        (clk),
        .nrst       (nrst),
        .data_in    (data_in0),
        .fifo_empty (fifo_empty0),
        .data_rd    (data_rd0),
        .tx_en      (tx_en0),
        .uclk       (uclk0),
        .txd        (txd0),
        .busy       (busy0)
    );

    upuart_tx #(
        .OVERSAMPLE (8),
        .STOP_BITS  (2)
    ) u_dut1 (
        .clk        (clk),
        .nrst       (nrst),
        .data_in    (data_in1),
        .fifo_empty (fifo_empty1),
        .data_rd    (data_rd1),
        .tx_en      (tx_en1),
        .uclk       (uclk1),
        .txd        (txd1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uclk for dut0: high for one clk out of every four.
    initial begin
        div0  = 0;
        uclk0 = 1'b0;
        uclk1 = 1'b1;
    end
    always @(negedge clk) begin
        div0  = (div0 + 1) % 4;
        uclk0 = (div0 == 0);
    end

    // FIFO models: pop on the strobe, head stays visible (first-word-fall-through).
    always @(negedge clk) begin
        logic [7:0] tmp;
        if (data_rd0 === 1'b1 && q0.size() > 0) begin
            tmp         = q0.pop_front();
            fifo_empty0 = (q0.size() == 0);
            data_in0    = (q0.size() > 0) ? q0[0] : 8'h00;
        end
        if (data_rd1 === 1'b1 && q1.size() > 0) begin
            tmp         = q1.pop_front();
            fifo_empty1 = (q1.size() == 0);
            data_in1    = (q1.size() > 0) ? q1[0] : 8'h00;
        end
    end

    // Receiver model for dut1's line: 8 clk per bit, samples at mid-bit.
    initial begin
        rx_ferr = 0;
        rx_prev = 1'b1;
    end
    always begin
        logic [7:0] b;
        @(negedge clk);
        if (nrst === 1'b1 && rx_prev === 1'b1 && txd1 === 1'b0) begin
            repeat (4) @(negedge clk);
            if (txd1 !== 1'b0) rx_ferr++;
            for (int i = 0; i < 8; i++) begin
                repeat (8) @(negedge clk);
                b[i] = txd1;
            end
            for (int i = 0; i < 2; i++) begin
                repeat (8) @(negedge clk);
                if (txd1 !== 1'b1) rx_ferr++;
            end
            rx_q.push_back(b);
            rx_prev = 1'b1;
        end else begin
            rx_prev = txd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [7:0] b);
        q0.push_back(b);
        fifo_empty0 = 1'b0;
        data_in0    = q0[0];
    endtask

    task automatic push1(input logic [7:0] b);
        q1.push_back(b);
        fifo_empty1 = 1'b0;
        data_in1    = q1[0];
    endtask

    // Waits (bounded) for a pop strobe on the monitored DUT. Returns at the
    // falling edge right after the start edge.
    task automatic wait_start(input string tag, input int budget, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            waited++;
            if (mon_rd === 1'b1) found = 1'b1;
        end
        if (!found) check({tag, " start timeout"}, 32'd0, 32'd1);
    endtask

    // Checks every clk of one frame against the expected waveform. Entered at
    // the falling edge right after the start edge; returns at the last falling
    // edge of the frame. drop_at >= 0 drops dut0's tx_en at that cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input int bit_clks,
                               input int nstop, input int drop_at);
        int   frame_clks;
        int   bi;
        logic exp_txd;
        frame_clks = (9 + nstop) * bit_clks;
        for (int c = 0; c < frame_clks; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) tx_en0 = 1'b0;
            bi = c / bit_clks;
            if (bi == 0)      exp_txd = 1'b0;
            else if (bi <= 8) exp_txd = b[bi-1];
            else              exp_txd = 1'b1;
            check($sformatf("%s txd c=%0d", tag, c), 32'(mon_txd), 32'(exp_txd));
            check($sformatf("%s busy c=%0d", tag, c), 32'(mon_busy), 32'd1);
            check($sformatf("%s data_rd c=%0d", tag, c), 32'(mon_rd), (c == 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s idle txd c=%0d", tag, c), 32'(mon_txd), 32'd1);
            check($sformatf("%s idle busy c=%0d", tag, c), 32'(mon_busy), 32'd0);
            check($sformatf("%s idle data_rd c=%0d", tag, c), 32'(mon_rd), 32'd0);
        end
    endtask

    initial begin
        int waited;
        n_checks    = 0;
        n_errors    = 0;
        sel         = 1'b0;
        nrst        = 1'b0;
        tx_en0      = 1'b0;
        tx_en1      = 1'b0;
        data_in0    = 8'h00;
        data_in1    = 8'h00;
        fifo_empty0 = 1'b1;
        fifo_empty1 = 1'b1;

        // ---- Reset held with random inputs ----
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            data_in0    = 8'($urandom);
            fifo_empty0 = 1'($urandom);
            tx_en0      = 1'($urandom);
            data_in1    = 8'($urandom);
            fifo_empty1 = 1'($urandom);
            tx_en1      = 1'($urandom);
            #1;
            check("rst txd0", 32'(txd0), 32'd1);
            check("rst data_rd0", 32'(data_rd0), 32'd0);
            check("rst busy0", 32'(busy0), 32'd0);
            check("rst txd1", 32'(txd1), 32'd1);
            check("rst data_rd1", 32'(data_rd1), 32'd0);
            check("rst busy1", 32'(busy1), 32'd0);
        end
        @(negedge clk);
        data_in0    = 8'h00;
        fifo_empty0 = 1'b1;
        tx_en0      = 1'b1;
        data_in1    = 8'h00;
        fifo_empty1 = 1'b1;
        tx_en1      = 1'b0;
        nrst        = 1'b1;
        check_idle("post_rst", 200);

        // ---- Single byte 0xA5 ----
        push0(8'hA5);
        wait_start("a5", 8, waited);
        check_frame("a5", 8'hA5, 64, 1, -1);
        check_idle("a5", 40);

        // ---- Back-to-back 0x00 then 0xFF ----
        push0(8'h00);
        push0(8'hFF);
        wait_start("b2b", 8, waited);
        check_frame("b2b0", 8'h00, 64, 1, -1);
        @(negedge clk);
        check_frame("b2b1", 8'hFF, 64, 1, -1);
        check_idle("b2b", 40);

        // ---- Enable gating: tx_en drops during data bit 3 of 0x3C ----
        push0(8'h3C);
        push0(8'h55);
        wait_start("gate", 8, waited);
        check_frame("gate", 8'h3C, 64, 1, 4 * 64 + 10);
        check_idle("gate_off", 100);
        tx_en0 = 1'b1;
        wait_start("gate_on", 8, waited);
        check("gate_on latency", 32'(waited <= 4), 32'd1);
        check_frame("gate55", 8'h55, 64, 1, -1);
        check_idle("gate55", 40);

        // ---- Reset during data bit 5, then 0x81 from a clean start ----
        push0(8'h5A);
        push0(8'h81);
        wait_start("midrst", 8, waited);
        repeat (6 * 64 + 20) @(negedge clk);
        check("midrst pre busy", 32'(busy0), 32'd1);
        nrst = 1'b0;
        #1;
        check("midrst txd", 32'(txd0), 32'd1);
        check("midrst busy", 32'(busy0), 32'd0);
        check("midrst data_rd", 32'(data_rd0), 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        wait_start("after_rst", 8, waited);
        check_frame("x81", 8'h81, 64, 1, -1);
        check_idle("x81", 40);

        // ---- dut1: OVERSAMPLE=8, STOP_BITS=2, uclk tied high ----
        sel = 1'b1;
        push1(8'hC3);
        push1(8'h3A);
        tx_en1 = 1'b1;
        wait_start("cfg", 4, waited);
        check_frame("cfgC3", 8'hC3, 8, 2, -1);
        @(negedge clk);
        check_frame("cfg3A", 8'h3A, 8, 2, -1);
        check_idle("cfg", 20);
        check("loopback count", 32'(rx_q.size()), 32'd2);
        check("loopback byte0", 32'(rx_q[0]), 32'hC3);
        check("loopback byte1", 32'(rx_q[1]), 32'h3A);
        check("loopback framing", 32'(rx_ferr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
